demux1x2_pipe: RTL and testbench
================================

// Module: demux1x2_pipe
// PURPOSE
// - Registered 1:2 demultiplexer, the inverse of the 2:1 datapath mux: one valid/ready input stream
//   is steered by in_sel to one of two valid/ready output streams.
// - Each output is buffered by a small FIFO, so a stalled consumer does not block the other output.
// - Used in the pipelined RISC datapath to split stage results between two consumers,
//   e.g. the register-file writeback path and the memory path, with a pipeline flush on redirect.
// PARAMETERS
// - WIDTH  32  data width of the input and both outputs
// - DEPTH   2  entries per output FIFO; power of 2, >= 2
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous, active-low reset
// - flush       in   1      synchronous clear of both FIFOs
// - in_valid    in   1      input word present
// - in_ready    out  1      input word accepted this cycle when in_valid & in_ready
// - in_sel      in   1      0 -> output 0, 1 -> output 1; sampled with in_data
// - in_data     in   WIDTH  input word
// - out0_valid  out  1      FIFO 0 not empty
// - out0_ready  in   1      consumer 0 pops the head when out0_valid & out0_ready
// - out0_data   out  WIDTH  head of FIFO 0; 0 when empty
// - out1_valid  out  1      FIFO 1 not empty
// - out1_ready  in   1      consumer 1 pops the head when out1_valid & out1_ready
// - out1_data   out  WIDTH  head of FIFO 1; 0 when empty
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): both counts and pointers = 0; outX_valid = 0; outX_data = 0;
//   in_ready = 0 while reset is asserted.
// - Reset mid-operation discards all buffered words; there is no partial state.
// - Push: an input word accepted on edge N is visible on outX_valid/outX_data after edge N (latency 1).
//   There is no combinational path from in_data to outX_data.
// - in_ready = !flush & (count[in_sel] < DEPTH | out[in_sel]_ready).
//   - in_ready depends on in_sel; a full FIFO accepts a push in the same cycle it is popped.
//   - in_ready ignores the state of the unselected FIFO.
// - Pop: outX_valid & outX_ready advance the read pointer on the edge.
// - Count per FIFO:
//   - push only: +1; pop only: -1; push and pop together: unchanged.
//   - push and pop on an empty FIFO cannot occur, because valid is registered.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
// - Order is preserved per output. There is no ordering guarantee between the two outputs.
// - Data rules: no width change; in_data is stored verbatim. in_sel is not stored.
// - flush=1 on an edge:
//   - both FIFOs empty after the edge;
//   - no push that cycle, since in_ready is 0;
//   - pops that cycle are void.
// - flush=1 with in_valid=1: the word is not taken. The producer must hold or drop it under its own flush.
// - Simultaneous push to FIFO 0 and pop from FIFO 1 are independent; both occur.
// - Invariant: overflow or underflow is impossible by construction; assertions check count <= DEPTH.
// STRUCTURE
// - Package demux_pkg holds: localparam SEL_OUT0=1'b0, SEL_OUT1=1'b1, and a function clog2_min1.
// - Sub-module demux_fifo is instantiated twice.
//   - Parameters: WIDTH, DEPTH.
//   - Ports: clk, rst_n, clr, push, wdata, pop, full, empty, rdata (0 when empty).
// - The top level computes per-FIFO push = in_valid & in_ready & (in_sel==X)
//   and pop = outX_valid & outX_ready.
// TESTING
// - Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out0_valid=out1_valid=0, data=0.
// - Steering: push 32'h12345678 sel=0, then 32'hABCDEF01 sel=1, both readies=1
//   -> out0_data=12345678 one cycle after the first push, out1_data=ABCDEF01 one cycle after the second.
// - Backpressure: out0_ready=0, push 3 words sel=0 with DEPTH=2
//   -> in_ready drops after 2 accepts.
//   - A sel=1 push is still accepted.
//   - Raising out0_ready drains the words in order and accepts the third.
// - Full pass-through: FIFO 0 full, out0_ready=1, in_valid=1 sel=0 -> push and pop on the same edge,
//   count stays 2, order 00000000 -> FFFFFFFF preserved.
// - Flush: both FIFOs hold 1 word, assert flush with in_valid=1
//   -> in_ready=0, both outX_valid=0 next cycle, the flushed-cycle input is not taken.
// - Async reset mid-stream: drop rst_n between clock edges with FIFOs non-empty
//   -> outputs clear immediately, with no wait for clk.

Source files
------------

// File: rtl/demux1x2_pipe_pkg.sv
// Shared constants and helpers for the registered 1:2 stream demultiplexer.
package demux_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Pointer width for a DEPTH-entry buffer, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux1x2_pipe_if.sv
// Input stream plus the two steered output streams of demux1x2_pipe.
interface demux1x2_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux1x2_pipe_fifo.sv
// Small synchronous FIFO with async reset and synchronous clear; rdata reads 0 when empty.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A clear voids any push or pop presented in the same cycle.
  assign do_push = push & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/demux1x2_pipe.sv
// Registered 1:2 demultiplexer: steers one valid/ready stream into two independently buffered outputs.
module demux1x2_pipe
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  demux1x2_pipe_if.slave    bus
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic sel_room;
  logic accept;

  // Only the selected FIFO gates acceptance; a full FIFO still takes a word when it pops this cycle.
  assign sel_room     = (bus.in_sel == SEL_OUT1) ? (~full1 | bus.out1_ready)
                                                 : (~full0 | bus.out0_ready);
  assign bus.in_ready = rst_n & ~flush & sel_room;
  assign accept       = bus.in_valid & bus.in_ready;

  assign push0 = accept & (bus.in_sel == SEL_OUT0);
  assign push1 = accept & (bus.in_sel == SEL_OUT1);
  assign pop0  = ~empty0 & bus.out0_ready;
  assign pop1  = ~empty1 & bus.out1_ready;

  assign bus.out0_valid = ~empty0;
  assign bus.out1_valid = ~empty1;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push0),
    .wdata (bus.in_data),
    .pop   (pop0),
    .full  (full0),
    .empty (empty0),
    .rdata (bus.out0_data)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push1),
    .wdata (bus.in_data),
    .pop   (pop1),
    .full  (full1),
    .empty (empty1),
    .rdata (bus.out1_data)
  );

endmodule

// File: tb/tb_demux1x2_pipe.sv
// Bench for demux1x2_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_demux1x2_pipe;
  localparam int unsigned W = 32;
  localparam int unsigned D = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  demux1x2_pipe_if #(.WIDTH(W)) bus ();

  demux1x2_pipe #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic         m_acc, m_pop0, m_pop1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_ready();
    if (!rst_n || flush) return 1'b0;
    if (bus.in_sel) return (q1.size() < D) || bus.out1_ready;
    return (q0.size() < D) || bus.out0_ready;
  endfunction

  // Reference: pops leave the head, then an accepted word joins the tail of its queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      m_acc  = bus.in_valid && model_ready();
      m_pop0 = (q0.size() != 0) && bus.out0_ready;
      m_pop1 = (q1.size() != 0) && bus.out1_ready;
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) void'(q1.pop_front());
      if (m_acc) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready",   W'(bus.in_ready),   W'(model_ready()));
    chk("m_out0_valid", W'(bus.out0_valid), W'(q0.size() != 0));
    chk("m_out1_valid", W'(bus.out1_valid), W'(q1.size() != 0));
    chk("m_out0_data",  bus.out0_data, (q0.size() != 0) ? q0[0] : '0);
    chk("m_out1_data",  bus.out1_data, (q1.size() != 0) ? q1[0] : '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    #1;
    chk("rst_in_ready",   W'(bus.in_ready),   '0);
    chk("rst_out0_valid", W'(bus.out0_valid), '0);
    chk("rst_out1_valid", W'(bus.out1_valid), '0);
    chk("rst_out0_data",  bus.out0_data,      '0);
    tick(); tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);

    // steering
    drive(1'b1, 1'b0, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b1, 32'hABCD_EF01);
    #1;
    chk("steer_out0_valid", W'(bus.out0_valid), 32'd1);
    chk("steer_out0_data",  bus.out0_data,      32'h1234_5678);
    tick();
    chk("steer_out1_data",  bus.out1_data,      32'hABCD_EF01);
    chk("steer_out0_drain", W'(bus.out0_valid), 32'd0);
    drive(1'b0, 1'b0, '0);
    tick();

    // backpressure on output 0
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_00A0);
    tick();
    drive(1'b1, 1'b0, 32'h0000_00A1);
    tick();
    drive(1'b1, 1'b0, 32'h0000_00A2);
    #1;
    chk("bp_full_in_ready", W'(bus.in_ready), 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_00B0);
    #1;
    chk("bp_other_in_ready", W'(bus.in_ready), 32'd1);
    tick();
    chk("bp_out1_data", bus.out1_data, 32'h0000_00B0);
    drive(1'b1, 1'b0, 32'h0000_00A2);
    bus.out0_ready = 1'b1;
    #1;
    chk("bp_popready_in_ready", W'(bus.in_ready), 32'd1);
    tick();
    chk("bp_drain_a1", bus.out0_data, 32'h0000_00A1);
    drive(1'b0, 1'b0, '0);
    tick();
    chk("bp_drain_a2", bus.out0_data, 32'h0000_00A2);
    tick();
    chk("bp_empty", W'(bus.out0_valid), 32'd0);

    // full pass-through
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0000);
    tick();
    drive(1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    bus.out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h5555_5555);
    #1;
    chk("pt_head0",     bus.out0_data,      32'h0000_0000);
    chk("pt_in_ready",  W'(bus.in_ready),   32'd1);
    tick();
    chk("pt_headff",    bus.out0_data,      32'hFFFF_FFFF);
    drive(1'b0, 1'b0, '0);
    tick();
    chk("pt_head55",    bus.out0_data,      32'h5555_5555);
    tick();
    chk("pt_empty",     W'(bus.out0_valid), 32'd0);

    // flush
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_00C0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_00C1);
    tick();
    flush = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_00C2);
    #1;
    chk("fl_in_ready", W'(bus.in_ready), 32'd0);
    chk("fl_pre_out1", bus.out1_data,    32'h0000_00C1);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    #1;
    chk("fl_out0_valid", W'(bus.out0_valid), 32'd0);
    chk("fl_out1_valid", W'(bus.out1_valid), 32'd0);
    tick();
    chk("fl_not_taken", W'(bus.out0_valid), 32'd0);

    // asynchronous reset mid-stream
    drive(1'b1, 1'b0, 32'h0000_00D0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_00D1);
    tick();
    drive(1'b0, 1'b0, '0);
    #2;
    chk("ar_pre_out0", bus.out0_data, 32'h0000_00D0);
    rst_n = 1'b0;
    #1;
    chk("ar_out0_valid", W'(bus.out0_valid), 32'd0);
    chk("ar_out1_valid", W'(bus.out1_valid), 32'd0);
    chk("ar_out0_data",  bus.out0_data,      '0);
    chk("ar_out1_data",  bus.out1_data,      '0);
    chk("ar_in_ready",   W'(bus.in_ready),   '0);
    tick(); tick();
    rst_n = 1'b1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_00E0);
    tick();
    drive(1'b0, 1'b0, '0);
    chk("ar_recover", bus.out0_data, 32'h0000_00E0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
